// File: rtl/fwd_fft_mul_pkg.sv
// Shared constants and saturation-limit helpers for the forward-FFT multiplier.
// Latency: n/a (package).
// Backpressure: n/a (package).
package fwd_fft_mul_pkg;

   localparam int MAX_STAGE = 8;
   // Widest internal datapath the helpers can describe.
   localparam int MAX_W     = 64;

   // Largest representable value of a width-bit result, zero-extended to MAX_W.
   function automatic logic [MAX_W-1:0] sat_max(input int width, input bit is_signed);
      logic [MAX_W-1:0] v;
      v = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < (is_signed ? width - 1 : width)) v[i] = 1'b1;
      end
      return v;
   endfunction

   // Smallest representable value, sign-extended to MAX_W so any low slice keeps its value.
   function automatic logic [MAX_W-1:0] sat_min(input int width, input bit is_signed);
      logic [MAX_W-1:0] v;
      v = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (is_signed && (i >= width - 1)) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/fwd_fft_mul_pipe_if.sv
// Operand/result bundle of the forward-FFT multiplier pipeline.
// Latency: n/a (interface only).
// Backpressure: none; ce is a global stall, there is no ready.
// Signals: ce, in_valid, a, b, ovf_clr (master -> slave); out_valid, dout, ovf (slave -> master).
interface fwd_fft_mul_pipe_if #(
   parameter int A_W   = 24,
   parameter int B_W   = 16,
   parameter int OUT_W = 32
) ();

   logic             ce;
   logic             in_valid;
   logic [A_W-1:0]   a;
   logic [B_W-1:0]   b;
   logic             ovf_clr;
   logic             out_valid;
   logic [OUT_W-1:0] dout;
   logic             ovf;

   modport master (
      output ce, in_valid, a, b, ovf_clr,
      input  out_valid, dout, ovf
   );

   modport slave (
      input  ce, in_valid, a, b, ovf_clr,
      output out_valid, dout, ovf
   );

endinterface

// File: rtl/fwd_fft_mul_round_sat.sv
// Scales a full-width product by SHIFT (optionally rounding half up) and clamps it to OUT_W.
// Latency: 0 (purely combinational).
// Backpressure: none.
// Ports: prod_i full product in; res_o scaled/saturated result; sat_o high when clamping occurred.
// Build option: FWD_FFT_MUL_ROUND_EN adds 2^(SHIFT-1) before the shift.
module fwd_fft_mul_round_sat
   import fwd_fft_mul_pkg::*;
#(
   parameter int PW        = 40,
   parameter int OUT_W     = 32,
   parameter int SHIFT     = 0,
   parameter bit IS_SIGNED = 1'b0
) (
   input  logic [PW-1:0]    prod_i,
   output logic [OUT_W-1:0] res_o,
   output logic             sat_o
);

   // One guard bit above the product absorbs the rounding carry; also wide enough to
   // hold OUT_W plus a sign so the range compare is exact in every configuration.
   localparam int W = (PW + 1 > OUT_W + 1) ? PW + 1 : OUT_W + 1;

   localparam logic [MAX_W-1:0] SMAX = sat_max(OUT_W, IS_SIGNED);
   localparam logic [MAX_W-1:0] SMIN = sat_min(OUT_W, IS_SIGNED);

`ifdef FWD_FFT_MUL_ROUND_EN
   localparam int           RS      = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [W-1:0] RND_ADD = (SHIFT > 0) ? (W'(1) << RS) : '0;
`endif

   logic [W-1:0] ext;
   logic [W-1:0] sum;
   logic [W-1:0] shf;
   logic [W-1:0] hi_lim;
   logic [W-1:0] lo_lim;
   logic         over;
   logic         under;

   assign hi_lim = SMAX[W-1:0];
   assign lo_lim = SMIN[W-1:0];

   always_comb begin
      ext   = {{(W-PW){IS_SIGNED & prod_i[PW-1]}}, prod_i};
`ifdef FWD_FFT_MUL_ROUND_EN
      sum   = ext + RND_ADD;
`else
      sum   = ext;
`endif
      shf   = '0;
      over  = 1'b0;
      under = 1'b0;
      if (IS_SIGNED) begin
         shf   = $signed(sum) >>> SHIFT;
         over  = $signed(shf) > $signed(hi_lim);
         under = $signed(shf) < $signed(lo_lim);
      end else begin
         shf   = sum >> SHIFT;
         over  = shf > hi_lim;
      end
      sat_o = over | under;
      if (over)       res_o = hi_lim[OUT_W-1:0];
      else if (under) res_o = lo_lim[OUT_W-1:0];
      else            res_o = shf[OUT_W-1:0];
   end

endmodule

// File: rtl/fwd_fft_mul_pipe.sv
// Pipelined multiplier with per-operand signedness, SHIFT scaling, saturation and sticky overflow.
// Latency: exactly NUM_STAGE ce=1 edges from in_valid to out_valid; one result per ce=1 cycle.
// Backpressure: none; ce=0 freezes every register including valid and ovf.
// Ports: clk, reset (sync, active high); bus (slave) carries ce/in_valid/a/b/ovf_clr in and
//        out_valid/dout/ovf out.
// Build option: FWD_FFT_MUL_ROUND_EN selects round-half-up scaling instead of truncation.
module fwd_fft_mul_pipe
   import fwd_fft_mul_pkg::*;
#(
   parameter int A_W       = 24,
   parameter int B_W       = 16,
   parameter int OUT_W     = 32,
   parameter int SHIFT     = 0,
   parameter int NUM_STAGE = 4,
   parameter bit A_SIGNED  = 1'b0,
   parameter bit B_SIGNED  = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   fwd_fft_mul_pipe_if.slave bus
);

   localparam int PW        = A_W + B_W;
   localparam int PD        = NUM_STAGE - 2;   // product/balancing registers
   localparam bit IS_SIGNED = A_SIGNED | B_SIGNED;

   if (NUM_STAGE < 2 || NUM_STAGE > MAX_STAGE) begin : g_bad_stage
      $error("fwd_fft_mul_pipe: NUM_STAGE must be in 2..8");
   end
   if (SHIFT < 0 || SHIFT >= PW) begin : g_bad_shift
      $error("fwd_fft_mul_pipe: SHIFT must be in 0..A_W+B_W-1");
   end
   if (((PW + 1 > OUT_W + 1) ? PW + 1 : OUT_W + 1) > MAX_W) begin : g_bad_width
      $error("fwd_fft_mul_pipe: operand/output widths exceed the internal datapath");
   end

   // Stage 1: operand capture.
   logic [A_W-1:0] a_q;
   logic [B_W-1:0] b_q;
   logic           vld1_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q    <= '0;
         b_q    <= '0;
         vld1_q <= 1'b0;
      end else if (bus.ce) begin
         a_q    <= bus.a;
         b_q    <= bus.b;
         vld1_q <= bus.in_valid;
      end
   end

   // Extending both operands to PW makes the low PW bits of the product correct for
   // any signedness mix, and the true product always fits in PW bits.
   logic [PW-1:0] a_ext;
   logic [PW-1:0] b_ext;
   logic [PW-1:0] prod_c;

   assign a_ext  = {{B_W{A_SIGNED & a_q[A_W-1]}}, a_q};
   assign b_ext  = {{A_W{B_SIGNED & b_q[B_W-1]}}, b_q};
   assign prod_c = a_ext * b_ext;

   // Stages 2..NUM_STAGE-1: product register plus balancing delay.
   logic [PW-1:0] prod_fin;
   logic          vld_fin;

   if (PD == 0) begin : g_nobal
      assign prod_fin = prod_c;
      assign vld_fin  = vld1_q;
   end else begin : g_bal
      logic [PW-1:0] prod_q [PD];
      logic [PD-1:0] vld_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            for (int i = 0; i < PD; i++) prod_q[i] <= '0;
            vld_q <= '0;
         end else if (bus.ce) begin
            prod_q[0] <= prod_c;
            vld_q[0]  <= vld1_q;
            for (int i = 1; i < PD; i++) begin
               prod_q[i] <= prod_q[i-1];
               vld_q[i]  <= vld_q[i-1];
            end
         end
      end

      assign prod_fin = prod_q[PD-1];
      assign vld_fin  = vld_q[PD-1];
   end

   logic [OUT_W-1:0] res_c;
   logic             sat_c;

   fwd_fft_mul_round_sat #(
      .PW        (PW),
      .OUT_W     (OUT_W),
      .SHIFT     (SHIFT),
      .IS_SIGNED (IS_SIGNED)
   ) u_round_sat (
      .prod_i (prod_fin),
      .res_o  (res_c),
      .sat_o  (sat_c)
   );

   // Final stage: result register and sticky overflow.
   logic [OUT_W-1:0] dout_q;
   logic [OUT_W-1:0] dout_d;
   logic             out_vld_q;
   logic             ovf_q;
   logic             ovf_d;

   always_comb begin
      dout_d = res_c;
      ovf_d  = ovf_q;
      // A new saturation beats a simultaneous clear; invalid slots never flag.
      if (vld_fin && sat_c) ovf_d = 1'b1;
      else if (bus.ovf_clr) ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dout_q    <= '0;
         out_vld_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (bus.ce) begin
         dout_q    <= dout_d;
         out_vld_q <= vld_fin;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.dout      = dout_q;
   assign bus.out_valid = out_vld_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fwd_fft_mul_pipe.sv
// Scoreboard bench for fwd_fft_mul_pipe: a default unsigned instance (NUM_STAGE=4) and a
// signed Q15 instance (NUM_STAGE=2); expected results queued at drive time, popped on output.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_fwd_fft_mul_pipe;

`ifdef FWD_FFT_MUL_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   typedef struct {
      logic [63:0] dat;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   exp_t dq[$];
   exp_t qq[$];
   int   d_cnt  = 0;
   int   q_cnt  = 0;
   bit   d_seen = 1'b0;
   bit   q_seen = 1'b0;

   fwd_fft_mul_pipe_if #(.A_W(24), .B_W(16), .OUT_W(32)) d_if ();
   fwd_fft_mul_pipe_if #(.A_W(16), .B_W(16), .OUT_W(16)) q_if ();

   fwd_fft_mul_pipe #(
      .A_W(24), .B_W(16), .OUT_W(32), .SHIFT(0), .NUM_STAGE(4), .A_SIGNED(0), .B_SIGNED(0)
   ) u_def (
      .clk   (clk),
      .reset (reset),
      .bus   (d_if.slave)
   );

   fwd_fft_mul_pipe #(
      .A_W(16), .B_W(16), .OUT_W(16), .SHIFT(15), .NUM_STAGE(2), .A_SIGNED(1), .B_SIGNED(1)
   ) u_q15 (
      .clk   (clk),
      .reset (reset),
      .bus   (q_if.slave)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference arithmetic on 64-bit signed integers.
   function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input int aw, input int bw, input int ow,
                                         input int sh, input bit a_s, input bit b_s,
                                         input bit rnd);
      longint av, bv, p, r, mx, mn;
      av = a;
      bv = b;
      if (a_s && a[aw-1]) av = av - (longint'(1) <<< aw);
      if (b_s && b[bw-1]) bv = bv - (longint'(1) <<< bw);
      p = av * bv;
      if (rnd && sh > 0) p = p + (longint'(1) <<< (sh - 1));
      r = p >>> sh;
      if (a_s || b_s) begin
         mx = (longint'(1) <<< (ow - 1)) - 1;
         mn = -(longint'(1) <<< (ow - 1));
      end else begin
         mx = (longint'(1) <<< ow) - 1;
         mn = 0;
      end
      if (r > mx)      r = mx;
      else if (r < mn) r = mn;
      return 64'(r & ((longint'(1) <<< ow) - 1));
   endfunction

   // ce=1 edge counters, used as the latency reference.
   initial forever begin
      @(posedge clk);
      d_seen = d_if.ce && !reset;
      q_seen = q_if.ce && !reset;
      if (d_seen) d_cnt++;
      if (q_seen) q_cnt++;
   end

   initial begin : mon_d
      exp_t e;
      forever begin
         @(negedge clk);
         if (d_seen && d_if.out_valid) begin
            if (dq.size() == 0) chk("d_unexpected_out_valid", 64'd1, 64'd0);
            else begin
               e = dq.pop_front();
               chk("d_dout", 64'(d_if.dout), e.dat);
               chk("d_latency", 64'(d_cnt), 64'(e.due));
            end
         end
      end
   end

   initial begin : mon_q
      exp_t e;
      forever begin
         @(negedge clk);
         if (q_seen && q_if.out_valid) begin
            if (qq.size() == 0) chk("q_unexpected_out_valid", 64'd1, 64'd0);
            else begin
               e = qq.pop_front();
               chk("q_dout", 64'(q_if.dout), e.dat);
               chk("q_latency", 64'(q_cnt), 64'(e.due));
            end
         end
      end
   end

   // Drive one cycle on the falling edge, then return after the following falling edge.
   task automatic drv_d(input bit ce, input bit v, input logic [23:0] a, input logic [15:0] b,
                        input bit clr, input bit has_exp, input logic [63:0] xv);
      exp_t e;
      d_if.ce = ce; d_if.in_valid = v; d_if.a = a; d_if.b = b; d_if.ovf_clr = clr;
      if (ce && v) begin
         e.dat = has_exp ? xv : model(64'(a), 64'(b), 24, 16, 32, 0, 1'b0, 1'b0, RND);
         e.due = d_cnt + 4;
         dq.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drv_q(input bit ce, input bit v, input logic [15:0] a, input logic [15:0] b,
                        input bit clr, input bit has_exp, input logic [63:0] xv);
      exp_t e;
      q_if.ce = ce; q_if.in_valid = v; q_if.a = a; q_if.b = b; q_if.ovf_clr = clr;
      if (ce && v) begin
         e.dat = has_exp ? xv : model(64'(a), 64'(b), 16, 16, 16, 15, 1'b1, 1'b1, RND);
         e.due = q_cnt + 2;
         qq.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_d_out_valid"}, 64'(d_if.out_valid), 64'd0);
      chk({tag, "_d_dout"},      64'(d_if.dout),      64'd0);
      chk({tag, "_d_ovf"},       64'(d_if.ovf),       64'd0);
      chk({tag, "_q_out_valid"}, 64'(q_if.out_valid), 64'd0);
      chk({tag, "_q_dout"},      64'(q_if.dout),      64'd0);
      chk({tag, "_q_ovf"},       64'(q_if.ovf),       64'd0);
   endtask

   bit   pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   logic [23:0] ra;
   logic [15:0] rb;

   initial begin
      reset = 1'b1;
      d_if.ce = 1'b1; d_if.in_valid = 1'b0; d_if.a = '0; d_if.b = '0; d_if.ovf_clr = 1'b0;
      q_if.ce = 1'b1; q_if.in_valid = 1'b0; q_if.a = '0; q_if.b = '0; q_if.ovf_clr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      reset = 1'b0;

      // Unsigned overflow: product 40'hFF_FEFF_0001 clamps to all ones.
      drv_d(1, 1, 24'hFFFFFF, 16'hFFFF, 0, 1, 64'hFFFF_FFFF);
      repeat (4) drv_d(1, 0, '0, '0, 0, 0, '0);
      chk("t1_ovf", 64'(d_if.ovf), 64'd1);

      // Sticky flag: clear needs ce, clear alone works, set beats a simultaneous clear.
      drv_d(0, 0, '0, '0, 1, 0, '0);
      chk("ovf_hold_ce0", 64'(d_if.ovf), 64'd1);
      drv_d(1, 0, '0, '0, 1, 0, '0);
      chk("ovf_clr_alone", 64'(d_if.ovf), 64'd0);
      drv_d(1, 1, 24'hFFFFFF, 16'hFFFF, 0, 1, 64'hFFFF_FFFF);
      drv_d(1, 0, '0, '0, 0, 0, '0);
      drv_d(1, 0, '0, '0, 0, 0, '0);
      chk("ovf_before_land", 64'(d_if.ovf), 64'd0);
      drv_d(1, 0, '0, '0, 1, 0, '0);
      chk("ovf_set_beats_clr", 64'(d_if.ovf), 64'd1);
      drv_d(1, 0, '0, '0, 1, 0, '0);
      chk("ovf_clr_next", 64'(d_if.ovf), 64'd0);
      drv_d(1, 0, '0, '0, 0, 0, '0);

      // Signed Q15 points, including rounding and the negative boundary.
      drv_q(1, 1, 16'h4000, 16'h4000, 0, 1, 64'h2000);
      drv_q(1, 1, 16'h8000, 16'h8000, 0, 1, 64'h7FFF);
      drv_q(1, 1, 16'h0001, 16'h4000, 0, 1, RND ? 64'h0001 : 64'h0000);
      drv_q(1, 1, 16'h8000, 16'h7FFF, 0, 0, '0);
      drv_q(1, 1, 16'hFFFF, 16'h0001, 0, 0, '0);
      for (int i = 0; i < 8; i++) drv_q(1, 1, 16'($urandom), 16'($urandom), 0, 0, '0);
      repeat (4) drv_q(1, 0, '0, '0, 0, 0, '0);
      chk("q_ovf", 64'(q_if.ovf), 64'd1);
      chk("q_drained", 64'(qq.size()), 64'd0);

      // Back-to-back stream under a ce pattern 1,0,1,1,0...
      begin
         int n = 0;
         int k = 0;
         while (n < 10) begin
            if (n == 0) begin ra = 24'hFFFFFF; rb = 16'hFFFF; end
            else begin
               ra = 24'($urandom);
               rb = (n % 2 == 1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            end
            drv_d(pat[k % 5], 1, ra, rb, 0, 0, '0);
            if (pat[k % 5]) n++;
            k++;
         end
         for (int j = 0; j < 15; j++) begin
            drv_d(pat[k % 5], 0, '0, '0, 0, 0, '0);
            k++;
         end
      end
      chk("stream_drained", 64'(dq.size()), 64'd0);
      chk("stream_ovf", 64'(d_if.ovf), 64'd1);

      // Reset with three items in flight: nothing may emerge afterwards.
      for (int i = 0; i < 3; i++) drv_d(1, 1, 24'hFFFFFF, 16'h00FF + 16'(i), 0, 0, '0);
      reset = 1'b1;
      dq.delete();
      qq.delete();
      @(posedge clk);
      @(negedge clk);
      check_reset_state("midrst");
      reset = 1'b0;
      repeat (8) drv_d(1, 0, '0, '0, 0, 0, '0);
      chk("midrst_out_valid", 64'(d_if.out_valid), 64'd0);
      chk("midrst_ovf", 64'(d_if.ovf), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
